// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode enum, status flag indices, IEEE special constants
// and the per-operand exception class bundle.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } fpu_op_e;

    // Status vector order is {invalid, div_zero, overflow, underflow, inexact}
    localparam int FPU_FLAG_W = 5;
    localparam int FLG_INV    = 4;
    localparam int FLG_DZ     = 3;
    localparam int FLG_OVF    = 2;
    localparam int FLG_UNF    = 1;
    localparam int FLG_INX    = 0;

    localparam logic [31:0] FPU_QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] FPU_INF_MAG = 31'h7F80_0000;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } exc_class_t;

    function automatic logic [31:0] signed_inf(input logic s);
        return {s, FPU_INF_MAG};
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return {s, 31'h0};
    endfunction

endpackage

// File: rtl/fpu_except_resolve_if.sv
// Upstream operand/core beat and downstream result beat of the exception resolver.
// The resolver is the slave; the producer/consumer side is the master.
interface fpu_except_resolve_if
    import fpu_pkg::*;
#(
    parameter int FLAG_W = FPU_FLAG_W
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fpu_op;
    logic              sign_a;
    logic              sign_b;
    logic              opa_nan;
    logic              opb_nan;
    logic              opa_snan;
    logic              opb_snan;
    logic              opa_inf;
    logic              opb_inf;
    logic              opa_00;
    logic              opb_00;
    logic [31:0]       core_result;
    logic              core_ovf;
    logic              core_unf;
    logic              core_inx;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       result;
    logic [FLAG_W-1:0] flags;

    modport slave (
        input  in_valid, fpu_op, sign_a, sign_b,
        input  opa_nan, opb_nan, opa_snan, opb_snan,
        input  opa_inf, opb_inf, opa_00, opb_00,
        input  core_result, core_ovf, core_unf, core_inx,
        input  out_ready,
        output in_ready, out_valid, result, flags
    );

    modport master (
        output in_valid, fpu_op, sign_a, sign_b,
        output opa_nan, opb_nan, opa_snan, opb_snan,
        output opa_inf, opb_inf, opa_00, opb_00,
        output core_result, core_ovf, core_unf, core_inx,
        output out_ready,
        input  in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fpu_special_sel.sv
// Combinational priority selector: replaces the raw core result with the IEEE-754
// special value where the operand classes demand it and derives the status flags.
module fpu_special_sel
    import fpu_pkg::*;
#(
    parameter logic [31:0] QNAN_VAL = FPU_QNAN,
    parameter int          FLAG_W   = FPU_FLAG_W
) (
    input  logic [2:0]        fpu_op,
    input  logic              sign_a,
    input  logic              sign_b,
    input  exc_class_t        cls_a,
    input  exc_class_t        cls_b,
    input  logic [31:0]       core_result,
    input  logic              core_ovf,
    input  logic              core_unf,
    input  logic              core_inx,
    output logic [31:0]       sel_result,
    output logic [FLAG_W-1:0] sel_flags
);

    logic reserved_op;
    logic is_addsub;
    logic is_mul;
    logic is_div;
    logic sign_b_eff;
    logic eff_sub;
    logic sign_x;
    logic any_nan;
    logic any_snan;
    logic invalid_op;
    logic div_by_zero;

    assign reserved_op = fpu_op[2];
    assign is_addsub   = (fpu_op == OP_ADD) || (fpu_op == OP_SUB);
    assign is_mul      = (fpu_op == OP_MUL);
    assign is_div      = (fpu_op == OP_DIV);

    // Subtraction flips the sign b contributes, so b's effective sign drives inf results
    assign sign_b_eff  = sign_b ^ (fpu_op == OP_SUB);
    assign eff_sub     = sign_a ^ sign_b_eff;
    assign sign_x      = sign_a ^ sign_b;

    assign any_nan     = cls_a.nan  | cls_b.nan;
    assign any_snan    = cls_a.snan | cls_b.snan;

    assign invalid_op  = (is_addsub && cls_a.inf && cls_b.inf && eff_sub)
                       || (is_mul && ((cls_a.inf && cls_b.zero) || (cls_a.zero && cls_b.inf)))
                       || (is_div && ((cls_a.zero && cls_b.zero) || (cls_a.inf && cls_b.inf)));

    assign div_by_zero = is_div && cls_b.zero && !cls_a.inf && !cls_a.zero;

    always_comb begin
        sel_result = core_result;
        sel_flags  = '0;
        if (reserved_op) begin
            sel_result = core_result;
        end else if (any_nan) begin
            sel_result         = QNAN_VAL;
            sel_flags[FLG_INV] = any_snan;
        end else if (invalid_op) begin
            sel_result         = QNAN_VAL;
            sel_flags[FLG_INV] = 1'b1;
        end else if (div_by_zero) begin
            sel_result        = signed_inf(sign_x);
            sel_flags[FLG_DZ] = 1'b1;
        end else if (cls_a.inf || cls_b.inf) begin
            if (is_addsub) begin
                sel_result = signed_inf(cls_a.inf ? sign_a : sign_b_eff);
            end else if (is_div && cls_b.inf) begin
                sel_result = signed_zero(sign_x);
            end else begin
                sel_result = signed_inf(sign_x);
            end
        end else if (core_ovf) begin
            sel_result         = signed_inf(core_result[31]);
            sel_flags[FLG_OVF] = 1'b1;
            sel_flags[FLG_INX] = 1'b1;
        end else begin
            sel_result         = core_result;
            sel_flags[FLG_UNF] = core_unf;
            sel_flags[FLG_INX] = core_inx;
        end
    end

endmodule

// File: rtl/fpu_except_resolve.sv
// FPU exception resolver: two-stage valid/ready pipeline (select stage, output register)
// plus the software-visible sticky status register.
module fpu_except_resolve
    import fpu_pkg::*;
#(
    parameter logic [31:0] QNAN_VAL = FPU_QNAN,
    parameter int          FLAG_W   = FPU_FLAG_W
) (
    input  logic              clk,
    input  logic              rst,
    fpu_except_resolve_if.slave bus,
    input  logic              status_clr,
    output logic [FLAG_W-1:0] status
);

    exc_class_t        cls_a;
    exc_class_t        cls_b;
    logic [31:0]       sel_result;
    logic [FLAG_W-1:0] sel_flags;

    logic              s1_valid_q, s1_valid_d;
    logic [31:0]       s1_result_q, s1_result_d;
    logic [FLAG_W-1:0] s1_flags_q, s1_flags_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_result_q, s2_result_d;
    logic [FLAG_W-1:0] s2_flags_q, s2_flags_d;
    logic [FLAG_W-1:0] status_q, status_d;

    logic              s1_adv;
    logic              s2_adv;
    logic              accept;
    logic              deliver;

    assign cls_a = '{nan: bus.opa_nan, snan: bus.opa_snan, inf: bus.opa_inf, zero: bus.opa_00};
    assign cls_b = '{nan: bus.opb_nan, snan: bus.opb_snan, inf: bus.opb_inf, zero: bus.opb_00};

    fpu_special_sel #(
        .QNAN_VAL (QNAN_VAL),
        .FLAG_W   (FLAG_W)
    ) u_sel (
        .fpu_op      (bus.fpu_op),
        .sign_a      (bus.sign_a),
        .sign_b      (bus.sign_b),
        .cls_a       (cls_a),
        .cls_b       (cls_b),
        .core_result (bus.core_result),
        .core_ovf    (bus.core_ovf),
        .core_unf    (bus.core_unf),
        .core_inx    (bus.core_inx),
        .sel_result  (sel_result),
        .sel_flags   (sel_flags)
    );

    // Ready looks through both stages so a full pipe still streams one beat per cycle
    assign s2_adv  = !s2_valid_q || bus.out_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign accept  = bus.in_valid && bus.in_ready;
    assign deliver = s2_valid_q && bus.out_ready;

    assign bus.in_ready  = !rst && s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_result_q;
    assign bus.flags     = s2_flags_q;
    assign status        = status_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_result_d = s1_result_q;
        s1_flags_d  = s1_flags_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;

        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_result_d = sel_result;
                s1_flags_d  = sel_flags;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = s1_result_q;
                s2_flags_d  = s1_flags_q;
            end
        end

        // A clear coincident with a delivered beat still keeps that beat's flags
        status_d = (status_clr ? '0 : status_q) | (deliver ? s2_flags_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_result_q <= '0;
            s1_flags_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            status_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_result_q <= s1_result_d;
            s1_flags_q  <= s1_flags_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            status_q    <= status_d;
        end
    end

endmodule

// File: tb/tb_fpu_except_resolve.sv
// Self-checking bench for fpu_except_resolve: directed IEEE special cases, stall/ordering,
// sticky status behaviour and randomized traffic against an operation-level reference model.
module tb_fpu_except_resolve;

    localparam logic [2:0] C_NORM = 3'd0;
    localparam logic [2:0] C_ZERO = 3'd1;
    localparam logic [2:0] C_INF  = 3'd2;
    localparam logic [2:0] C_QNAN = 3'd3;
    localparam logic [2:0] C_SNAN = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [2:0]  op;
        logic        sa;
        logic        sb;
        logic [2:0]  ca;
        logic [2:0]  cb;
        logic [31:0] core;
        logic        ovf;
        logic        unf;
        logic        inx;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       status_clr;
    logic [4:0] status;

    int         n_cmp;
    int         n_fail;
    logic [4:0] stat_model;

    fpu_except_resolve_if bus ();

    fpu_except_resolve u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .status_clr (status_clr),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inf_of(input logic s);
        return s ? 32'hFF80_0000 : 32'h7F80_0000;
    endfunction

    // Reference model: IEEE special-case rules written per operation, result then flags
    function automatic logic [36:0] ref_model(input beat_t b);
        logic a_nan, b_nan, a_inf, b_inf, a_z, b_z, sp, eb;
        a_nan = (b.ca == C_QNAN) || (b.ca == C_SNAN);
        b_nan = (b.cb == C_QNAN) || (b.cb == C_SNAN);
        a_inf = (b.ca == C_INF);
        b_inf = (b.cb == C_INF);
        a_z   = (b.ca == C_ZERO);
        b_z   = (b.cb == C_ZERO);
        sp    = b.sa ^ b.sb;
        eb    = b.sb ^ (b.op == 3'd1);
        if (b.op > 3'd3) return {b.core, 5'b00000};
        if (a_nan || b_nan) return {QNAN, (b.ca == C_SNAN) || (b.cb == C_SNAN), 4'b0000};
        case (b.op)
            3'd0, 3'd1: begin
                if (a_inf && b_inf) return (b.sa != eb) ? {QNAN, 5'b10000} : {inf_of(b.sa), 5'b00000};
                if (a_inf) return {inf_of(b.sa), 5'b00000};
                if (b_inf) return {inf_of(eb), 5'b00000};
            end
            3'd2: begin
                if ((a_inf && b_z) || (a_z && b_inf)) return {QNAN, 5'b10000};
                if (a_inf || b_inf) return {inf_of(sp), 5'b00000};
            end
            default: begin
                if ((a_z && b_z) || (a_inf && b_inf)) return {QNAN, 5'b10000};
                if (a_inf) return {inf_of(sp), 5'b00000};
                if (b_inf) return {sp, 31'h0, 5'b00000};
                if (b_z) return {inf_of(sp), 5'b01000};
            end
        endcase
        if (b.ovf) return {inf_of(b.core[31]), 5'b00101};
        return {b.core, 3'b000, b.unf, b.inx};
    endfunction

    function automatic logic [2:0] rand_class();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return C_NORM;
        if (r == 5) return C_ZERO;
        if (r == 7) return C_QNAN;
        if (r == 8) return C_SNAN;
        return C_INF;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    r;
        r      = $urandom_range(0, 11);
        b.op   = (r < 10) ? 3'(r % 4) : 3'(r - 6);
        b.sa   = 1'($urandom_range(0, 1));
        b.sb   = 1'($urandom_range(0, 1));
        b.ca   = rand_class();
        b.cb   = rand_class();
        b.core = $urandom;
        b.ovf  = ($urandom_range(0, 7) == 0);
        b.unf  = ($urandom_range(0, 7) == 0);
        b.inx  = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic beat_t mk_beat(input logic [2:0] op, input logic sa, input logic sb,
                                      input logic [2:0] ca, input logic [2:0] cb,
                                      input logic [31:0] core, input logic ovf);
        beat_t b;
        b.op = op; b.sa = sa; b.sb = sb; b.ca = ca; b.cb = cb;
        b.core = core; b.ovf = ovf; b.unf = 1'b0; b.inx = 1'b0;
        return b;
    endfunction

    task automatic drive_beat(input beat_t b);
        bus.fpu_op      = b.op;
        bus.sign_a      = b.sa;
        bus.sign_b      = b.sb;
        bus.opa_nan     = (b.ca == C_QNAN) || (b.ca == C_SNAN);
        bus.opb_nan     = (b.cb == C_QNAN) || (b.cb == C_SNAN);
        bus.opa_snan    = (b.ca == C_SNAN);
        bus.opb_snan    = (b.cb == C_SNAN);
        bus.opa_inf     = (b.ca == C_INF);
        bus.opb_inf     = (b.cb == C_INF);
        bus.opa_00      = (b.ca == C_ZERO);
        bus.opb_00      = (b.cb == C_ZERO);
        bus.core_result = b.core;
        bus.core_ovf    = b.ovf;
        bus.core_unf    = b.unf;
        bus.core_inx    = b.inx;
    endtask

    // Push one beat into an empty pipe and collect it; no checks here, caller decides
    task automatic send_and_get(input beat_t b, output logic [31:0] r, output logic [4:0] f,
                                output int lat, output bit ok);
        drive_beat(b);
        status_clr    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        ok = 1'b0; lat = 0; r = '0; f = '0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.out_valid) begin
                r = bus.result; f = bus.flags; ok = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        n_cmp += 5;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", bus.result); end
        if (bus.flags !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000", bus.flags); end
        if (status !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_status: got %b expected 00000", status); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        stat_model = 5'b0;
    endtask

    task automatic test_directed();
        beat_t       vec [6];
        logic [31:0] exp_r [6];
        logic [4:0]  exp_f [6];
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        bit          ok;
        vec[0] = mk_beat(3'd0, 1'b0, 1'b1, C_INF,  C_INF,  32'h1234_5678, 1'b0);
        vec[1] = mk_beat(3'd3, 1'b0, 1'b0, C_NORM, C_ZERO, 32'h0000_0000, 1'b0);
        vec[2] = mk_beat(3'd3, 1'b1, 1'b0, C_NORM, C_ZERO, 32'h0000_0000, 1'b0);
        vec[3] = mk_beat(3'd2, 1'b0, 1'b0, C_SNAN, C_NORM, 32'h3F80_0000, 1'b0);
        vec[4] = mk_beat(3'd0, 1'b0, 1'b0, C_QNAN, C_NORM, 32'h7FC0_0001, 1'b0);
        vec[5] = mk_beat(3'd2, 1'b1, 1'b0, C_NORM, C_NORM, 32'hC000_0000, 1'b1);
        exp_r[0] = 32'h7FC0_0000; exp_f[0] = 5'b10000;
        exp_r[1] = 32'h7F80_0000; exp_f[1] = 5'b01000;
        exp_r[2] = 32'hFF80_0000; exp_f[2] = 5'b01000;
        exp_r[3] = 32'h7FC0_0000; exp_f[3] = 5'b10000;
        exp_r[4] = 32'h7FC0_0000; exp_f[4] = 5'b00000;
        exp_r[5] = 32'hFF80_0000; exp_f[5] = 5'b00101;
        for (int i = 0; i < 6; i++) begin
            send_and_get(vec[i], r, f, lat, ok);
            n_cmp += 3;
            if (!ok) begin n_fail++; $display("[TB] FAIL directed%0d_timeout: no out_valid within budget", i); end
            if (r !== exp_r[i]) begin n_fail++; $display("[TB] FAIL directed%0d_result: got %h expected %h", i, r, exp_r[i]); end
            if (f !== exp_f[i]) begin n_fail++; $display("[TB] FAIL directed%0d_flags: got %b expected %b", i, f, exp_f[i]); end
            n_cmp++;
            if (lat !== 2) begin n_fail++; $display("[TB] FAIL directed%0d_latency: got %0d expected 2", i, lat); end
            stat_model = stat_model | exp_f[i];
            if (i == 0) begin
                n_cmp++;
                if (status !== 5'b10000) begin n_fail++; $display("[TB] FAIL first_status: got %b expected 10000", status); end
            end
        end
        n_cmp++;
        if (status !== stat_model) begin n_fail++; $display("[TB] FAIL directed_status: got %b expected %b", status, stat_model); end
    endtask

    task automatic test_back_to_back();
        beat_t      b [4];
        logic [36:0] e [4];
        int         in_idx;
        int         out_idx;
        bit         rdy;
        for (int i = 0; i < 4; i++) begin
            b[i] = rand_beat();
            e[i] = ref_model(b[i]);
        end
        in_idx = 0; out_idx = 0;
        status_clr = 1'b0;
        for (int c = 0; c < 40 && out_idx < 4; c++) begin
            rdy = (c >= 5);
            bus.out_ready = rdy;
            bus.in_valid  = (in_idx < 4);
            if (in_idx < 4) drive_beat(b[in_idx]);
            #1;
            if (c == 2) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_in_ready_full: got %b expected 0", bus.in_ready); end
            end
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || {bus.result, bus.flags} !== e[0]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_hold: got v=%b %h/%b expected v=1 %h/%b", bus.out_valid, bus.result, bus.flags, e[0][36:5], e[0][4:0]);
                end
            end
            if (bus.out_valid && rdy) begin
                n_cmp++;
                if ({bus.result, bus.flags} !== e[out_idx]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_order%0d: got %h/%b expected %h/%b", out_idx, bus.result, bus.flags, e[out_idx][36:5], e[out_idx][4:0]);
                end
                stat_model = stat_model | e[out_idx][4:0];
                out_idx++;
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_cmp += 2;
        if (out_idx != 4) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d beats expected 4", out_idx); end
        #1;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_duplicate: got out_valid=%b expected 0", bus.out_valid); end
        n_cmp++;
        if (status !== stat_model) begin n_fail++; $display("[TB] FAIL b2b_status: got %b expected %b", status, stat_model); end
    endtask

    task automatic test_random();
        logic [36:0] exp_q [$];
        logic [36:0] e;
        beat_t       pend;
        bit          have_pend;
        bit          clr;
        bit          rdy;
        have_pend = 1'b0;
        pend      = rand_beat();
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (status !== stat_model) begin n_fail++; $display("[TB] FAIL rand_status@%0d: got %b expected %b", c, status, stat_model); end
            if (c < 360) begin
                if (!have_pend && $urandom_range(0, 3) != 0) begin
                    pend = rand_beat();
                    have_pend = 1'b1;
                end
                rdy = ($urandom_range(0, 9) < 7);
                clr = ($urandom_range(0, 19) == 0);
            end else begin
                rdy = 1'b1;
                clr = 1'b0;
            end
            bus.in_valid  = have_pend;
            drive_beat(pend);
            bus.out_ready = rdy;
            status_clr    = clr;
            #1;
            if (clr) stat_model = 5'b0;
            if (bus.out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rand_spurious@%0d: got %h/%b expected no beat", c, bus.result, bus.flags);
                end else begin
                    e = exp_q[0];
                    if ({bus.result, bus.flags} !== e) begin
                        n_fail++;
                        $display("[TB] FAIL rand_beat@%0d: got %h/%b expected %h/%b", c, bus.result, bus.flags, e[36:5], e[4:0]);
                    end
                    if (rdy) begin
                        stat_model = stat_model | e[4:0];
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (have_pend && bus.in_ready) begin
                exp_q.push_back(ref_model(pend));
                have_pend = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        status_clr   = 1'b0;
        n_cmp += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL rand_drain: got %0d beats left expected 0", exp_q.size()); end
        if (status !== stat_model) begin n_fail++; $display("[TB] FAIL rand_final_status: got %b expected %b", status, stat_model); end
    endtask

    task automatic test_status_clr_coincident();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        bit          ok;
        bit          seen;
        send_and_get(mk_beat(3'd3, 1'b0, 1'b0, C_NORM, C_ZERO, 32'h0, 1'b0), r, f, lat, ok);
        n_cmp++;
        if (status[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_pre_status: got %b expected bit3 set", status); end
        drive_beat(mk_beat(3'd2, 1'b0, 1'b0, C_SNAN, C_NORM, 32'h3F80_0000, 1'b0));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("[TB] FAIL clr_timeout: no out_valid within budget"); end
        bus.out_ready = 1'b1;
        status_clr    = 1'b1;
        @(posedge clk); #1;
        status_clr = 1'b0;
        stat_model = 5'b10000;
        n_cmp++;
        if (status !== 5'b10000) begin n_fail++; $display("[TB] FAIL clr_coincident: got %b expected 10000", status); end
    endtask

    task automatic test_reset_midflight();
        status_clr    = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_beat(mk_beat(3'd0, 1'b0, 1'b0, C_SNAN, C_NORM, 32'h0, 1'b0));
        @(posedge clk); #1;
        drive_beat(mk_beat(3'd2, 1'b0, 1'b0, C_INF, C_ZERO, 32'h0, 1'b0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_full_valid: got %b expected 1", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_full_ready: got %b expected 0", bus.in_ready); end
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
        if (status !== 5'b0) begin n_fail++; $display("[TB] FAIL mid_rst_status: got %b expected 00000", status); end
        if (bus.flags !== 5'b0) begin n_fail++; $display("[TB] FAIL mid_rst_flags: got %b expected 00000", bus.flags); end
        stat_model = 5'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_post_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp += 2;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_post_valid%0d: got %b expected 0", i, bus.out_valid); end
            if (status !== stat_model) begin n_fail++; $display("[TB] FAIL mid_post_status%0d: got %b expected %b", i, status, stat_model); end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; stat_model = 5'b0;
        rst = 1'b1;
        status_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_beat(mk_beat(3'd0, 1'b0, 1'b0, C_NORM, C_NORM, 32'h0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        $display("[TB] reset released");
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_status_clr_coincident();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
